// File: rtl/lfsr_scramble_ctrl.sv
// Frame sequencer and bit-stream handshake controller for a Fibonacci LFSR scrambler.
// Each frame is SYNC_LEN unscrambled sync bits followed by FRAME_LEN payload bits
// scrambled as in_bit ^ lfsr[0]. The LFSR is reseeded at every frame start.
module lfsr_scramble_ctrl #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  POLY      = 32'h00000061,
    parameter logic [WIDTH-1:0]  SEED_RST  = 32'h00000001,
    parameter int unsigned       FRAME_LEN = 64,
    parameter int unsigned       SYNC_LEN  = 8,
    parameter logic [31:0]       SYNC_WORD = 32'h000000A5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    input  logic             out_ready,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned SYNC_CW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam int unsigned PAY_CW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     lfsr;
    logic [WIDTH-1:0]     lfsr_next;
    logic [WIDTH-1:0]     seed_reg;
    logic [SYNC_CW-1:0]   sync_cnt;
    logic [SYNC_CW-1:0]   sync_cnt_next;
    logic [PAY_CW-1:0]    pay_cnt;
    logic [PAY_CW-1:0]    pay_cnt_next;

    logic                 slot_free;
    logic                 accept;
    logic                 sync_last;
    logic                 pay_last;
    logic                 sync_bit;
    logic [WIDTH-1:0]     seed_eff;
    logic [WIDTH-1:0]     reseed_val;
    logic [WIDTH-1:0]     lfsr_step;
    logic                 load;
    logic                 load_bit;
    logic                 load_fs;

    // Handshake and shared decode terms
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = (state == ST_PAYLOAD) && slot_free;
    assign accept     = in_valid && in_ready;
    assign sync_last  = (sync_cnt == SYNC_CW'(SYNC_LEN - 1));
    assign pay_last   = (pay_cnt == PAY_CW'(FRAME_LEN - 1));
    assign sync_bit   = SYNC_WORD[5'(sync_cnt)];
    assign busy       = (state != ST_IDLE) || out_valid;

    // A seed written in the reseed cycle wins; an all-zero seed would lock the LFSR, so use 1
    assign seed_eff   = seed_load ? seed : seed_reg;
    assign reseed_val = (seed_eff == '0) ? WIDTH'(1) : seed_eff;
    assign lfsr_step  = {^(lfsr & POLY), lfsr[WIDTH-1:1]};

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; frame progress only when the output slot can take a bit
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (slot_free && sync_last) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept && pay_last) begin
                    state_next = enable ? ST_SYNC : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/datapath decode: what to load into the line register and how counters/LFSR move
    always_comb begin
        load          = 1'b0;
        load_bit      = 1'b0;
        load_fs       = 1'b0;
        lfsr_next     = lfsr;
        sync_cnt_next = sync_cnt;
        pay_cnt_next  = pay_cnt;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    lfsr_next     = reseed_val;
                    sync_cnt_next = '0;
                end
            end
            ST_SYNC: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_bit = sync_bit;
                    load_fs  = (sync_cnt == '0);
                    if (sync_last) begin
                        pay_cnt_next = '0;
                    end else begin
                        sync_cnt_next = sync_cnt + SYNC_CW'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    load      = 1'b1;
                    load_bit  = in_bit ^ lfsr[0];
                    lfsr_next = lfsr_step;
                    if (pay_last) begin
                        pay_cnt_next = '0;
                        if (enable) begin
                            lfsr_next     = reseed_val;
                            sync_cnt_next = '0;
                        end
                    end else begin
                        pay_cnt_next = pay_cnt + PAY_CW'(1);
                    end
                end
            end
            default: begin
                sync_cnt_next = '0;
                pay_cnt_next  = '0;
            end
        endcase
    end

    // One-entry output buffer, LFSR, counters and seed register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            frame_start <= 1'b0;
            lfsr        <= SEED_RST;
            seed_reg    <= SEED_RST;
            sync_cnt    <= '0;
            pay_cnt     <= '0;
        end else begin
            if (load) begin
                out_valid   <= 1'b1;
                out_bit     <= load_bit;
                frame_start <= load_fs;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
                frame_start <= 1'b0;
            end
            if (seed_load) begin
                seed_reg <= seed;
            end
            lfsr     <= lfsr_next;
            sync_cnt <= sync_cnt_next;
            pay_cnt  <= pay_cnt_next;
        end
    end

endmodule

// File: tb/tb_lfsr_scramble_ctrl.sv
// Directed self-checking bench for lfsr_scramble_ctrl.
module tb_lfsr_scramble_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        seed_load;
    logic [31:0] seed;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        out_valid;
    logic        out_bit;
    logic        out_ready;
    logic        frame_start;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]  sync_pat = 8'hA5;
    logic        exp_line [72];

    always #5 clock = ~clock;

    lfsr_scramble_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .seed_load   (seed_load),
        .seed        (seed),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .out_ready   (out_ready),
        .frame_start (frame_start),
        .busy        (busy)
    );

    // Reference Fibonacci step with taps at bits 0, 5, 6
    function automatic logic [31:0] ref_step(input logic [31:0] x);
        return {^(x & 32'h00000061), x[31:1]};
    endfunction

    // Expected 72-bit line sequence for one frame given a seed and payload pattern
    task automatic build_line(input logic [31:0] s, input logic [63:0] p);
        logic [31:0] r;
        r = (s == 32'h0) ? 32'h1 : s;
        for (int j = 0; j < 8; j++) exp_line[j] = sync_pat[j];
        for (int j = 0; j < 64; j++) begin
            exp_line[8 + j] = p[j] ^ r[0];
            r = ref_step(r);
        end
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        seed_load = 1'b0;
        seed      = 32'h0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Bounded wait for the first line bit; leaves the bench on the negedge where it is visible
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (out_bit !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL reset_outs: out_bit=%b frame_start=%b expected 0 0", out_bit, frame_start);
        else pass_cnt++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            total_cnt++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_idle c=%0d: out_valid=%b in_ready=%b busy=%b expected 0 0 0",
                         c, out_valid, in_ready, busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_first_bits();
        bit ok;
        logic [7:0] exp_sync;
        exp_sync = 8'b1010_0101;
        do_reset();
        enable = 1'b1;
        wait_valid(ok);
        total_cnt++;
        if (!ok) $display("FAIL first_wait: out_valid=%b expected 1 within 10 cycles", out_valid);
        else pass_cnt++;
        if (ok) begin
            for (int j = 0; j < 8; j++) begin
                if (j > 0) @(negedge clock);
                total_cnt++;
                if (out_valid !== 1'b1 || out_bit !== exp_sync[j])
                    $display("FAIL first_sync j=%0d: valid=%b bit=%b expected 1 %b", j, out_valid, out_bit, exp_sync[j]);
                else pass_cnt++;
                total_cnt++;
                if (frame_start !== (j == 0))
                    $display("FAIL first_fs j=%0d: got %b expected %b", j, frame_start, (j == 0));
                else pass_cnt++;
            end
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL first_in_ready: got %b expected 1", in_ready);
            else pass_cnt++;
            in_valid = 1'b1;
            in_bit   = 1'b0;
            @(negedge clock);
            total_cnt++;
            if (out_valid !== 1'b1 || out_bit !== 1'b1)
                $display("FAIL first_pay0: valid=%b bit=%b expected 1 1", out_valid, out_bit);
            else pass_cnt++;
            @(negedge clock);
            total_cnt++;
            if (out_valid !== 1'b1 || out_bit !== 1'b0)
                $display("FAIL first_pay1: valid=%b bit=%b expected 1 0", out_valid, out_bit);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        enable   = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [63:0] pat;
        int acc;
        int idx;
        pat = 64'hC3A5_0F1E_9D27_6B48;
        acc = 0;
        do_reset();
        build_line(32'h1, pat);
        enable   = 1'b1;
        in_valid = 1'b1;
        wait_valid(ok);
        total_cnt++;
        if (!ok) $display("FAIL b2b_wait: out_valid=%b expected 1 within 10 cycles", out_valid);
        else pass_cnt++;
        if (ok) begin
            for (int c = 0; c < 144; c++) begin
                if (c > 0) @(negedge clock);
                idx = c % 72;
                total_cnt++;
                if (out_valid !== 1'b1 || out_bit !== exp_line[idx])
                    $display("FAIL b2b_bit c=%0d: valid=%b bit=%b expected 1 %b", c, out_valid, out_bit, exp_line[idx]);
                else pass_cnt++;
                total_cnt++;
                if (frame_start !== (idx == 0))
                    $display("FAIL b2b_fs c=%0d: got %b expected %b", c, frame_start, (idx == 0));
                else pass_cnt++;
                if (c == 140) enable = 1'b0;
                #1;
                if (in_ready === 1'b1) begin
                    in_bit = pat[acc % 64];
                    acc++;
                end
            end
            in_valid = 1'b0;
            @(negedge clock);
            total_cnt++;
            if (out_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL b2b_end: valid=%b busy=%b expected 0 0", out_valid, busy);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stall;
        logic [63:0] pat;
        int acc;
        int idx;
        int c;
        pat = 64'h5A5A_F00F_1234_ABCD;
        acc = 0;
        idx = 0;
        c   = 0;
        do_reset();
        build_line(32'h1, pat);
        enable   = 1'b1;
        in_valid = 1'b1;
        wait_valid(ok);
        enable = 1'b0;
        total_cnt++;
        if (!ok) $display("FAIL bp_wait: out_valid=%b expected 1 within 10 cycles", out_valid);
        else pass_cnt++;
        if (ok) begin
            while (idx < 72 && c < 100) begin
                if (c > 0) @(negedge clock);
                total_cnt++;
                if (out_valid !== 1'b1 || out_bit !== exp_line[idx])
                    $display("FAIL bp_bit c=%0d idx=%0d: valid=%b bit=%b expected 1 %b",
                             c, idx, out_valid, out_bit, exp_line[idx]);
                else pass_cnt++;
                stall     = (c >= 30 && c < 35);
                out_ready = !stall;
                #1;
                if (stall) begin
                    total_cnt++;
                    if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready);
                    else pass_cnt++;
                end
                if (in_ready === 1'b1) begin
                    in_bit = pat[acc % 64];
                    acc++;
                end
                if (out_ready) idx++;
                c++;
            end
            total_cnt++;
            if (idx != 72) $display("FAIL bp_count: delivered %0d bits expected 72", idx);
            else pass_cnt++;
            out_ready = 1'b1;
            in_valid  = 1'b0;
            @(negedge clock);
            total_cnt++;
            if (out_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL bp_end: valid=%b busy=%b expected 0 0", out_valid, busy);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
    endtask

    task automatic test_seed_load();
        bit ok;
        logic [63:0] pat;
        int acc;
        int idx;
        pat = 64'h0123_4567_89AB_CDEF;
        acc = 0;
        do_reset();
        enable   = 1'b1;
        in_valid = 1'b1;
        wait_valid(ok);
        total_cnt++;
        if (!ok) $display("FAIL seed_wait: out_valid=%b expected 1 within 10 cycles", out_valid);
        else pass_cnt++;
        if (ok) begin
            for (int c = 0; c < 216; c++) begin
                if (c > 0) @(negedge clock);
                idx = c % 72;
                if (c == 0)   build_line(32'h1, pat);
                if (c == 72)  build_line(32'h0, pat);
                if (c == 144) build_line(32'hDEADBEEF, pat);
                total_cnt++;
                if (out_valid !== 1'b1 || out_bit !== exp_line[idx])
                    $display("FAIL seed_bit c=%0d: valid=%b bit=%b expected 1 %b", c, out_valid, out_bit, exp_line[idx]);
                else pass_cnt++;
                if (c == 152) begin
                    total_cnt++;
                    if (out_bit !== (pat[0] ^ 1'b1))
                        $display("FAIL seed_beef_first: got %b expected %b", out_bit, pat[0] ^ 1'b1);
                    else pass_cnt++;
                end
                seed_load = 1'b0;
                if (c == 30) begin
                    seed      = 32'h0;
                    seed_load = 1'b1;
                end
                if (c == 100) begin
                    seed      = 32'hDEADBEEF;
                    seed_load = 1'b1;
                end
                if (c == 150) enable = 1'b0;
                #1;
                if (in_ready === 1'b1) begin
                    in_bit = pat[acc % 64];
                    acc++;
                end
            end
        end
        seed_load = 1'b0;
        in_valid  = 1'b0;
        enable    = 1'b0;
    endtask

    task automatic test_enable_stop();
        bit ok;
        logic [63:0] pat;
        int acc;
        pat = 64'hFEDC_BA98_7654_3210;
        acc = 0;
        do_reset();
        build_line(32'h1, pat);
        enable   = 1'b1;
        in_valid = 1'b1;
        wait_valid(ok);
        total_cnt++;
        if (!ok) $display("FAIL stop_wait: out_valid=%b expected 1 within 10 cycles", out_valid);
        else pass_cnt++;
        if (ok) begin
            for (int c = 0; c < 72; c++) begin
                if (c > 0) @(negedge clock);
                total_cnt++;
                if (out_valid !== 1'b1 || out_bit !== exp_line[c])
                    $display("FAIL stop_bit c=%0d: valid=%b bit=%b expected 1 %b", c, out_valid, out_bit, exp_line[c]);
                else pass_cnt++;
                if (c == 18) enable = 1'b0;
                #1;
                if (in_ready === 1'b1) begin
                    in_bit = pat[acc % 64];
                    acc++;
                end
            end
            total_cnt++;
            if (acc != 64) $display("FAIL stop_accepted: got %0d expected 64", acc);
            else pass_cnt++;
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                total_cnt++;
                if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || frame_start !== 1'b0)
                    $display("FAIL stop_idle c=%0d: valid=%b busy=%b in_ready=%b fs=%b expected 0 0 0 0",
                             c, out_valid, busy, in_ready, frame_start);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        enable = 1'b1;
        wait_valid(ok);
        repeat (2) @(negedge clock);
        total_cnt++;
        if (!ok || out_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL areset_pre: valid=%b busy=%b expected 1 1", out_valid, busy);
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0 || out_bit !== 1'b0)
            $display("FAIL areset_drop: valid=%b busy=%b fs=%b bit=%b expected 0 0 0 0",
                     out_valid, busy, frame_start, out_bit);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL areset_after: valid=%b busy=%b expected 0 0", out_valid, busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_bits();
        test_back_to_back();
        test_backpressure();
        test_seed_load();
        test_enable_stop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
